// File: rtl/cpu7_biu_pkg.sv
// cpu7_biu_pkg: shared encodings for the BIU arbiter slice.
// FSM state encoding, bus-owner constants and grant vector bit positions.
package cpu7_biu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } biu_state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

endpackage

// File: rtl/cpu7_biu_arb_pick.sv
// cpu7_biu_arb_pick: combinational grant select for the BIU arbiter.
// Optional macro CPU7_BIU_ARB_RR_EN: when defined, a tie goes to the requester
// that did not own the bus last; otherwise the LSU always wins a tie.
import cpu7_biu_pkg::*;

module cpu7_biu_arb_pick (
  input  logic       ifu_elig,
  input  logic       lsu_elig,
  input  logic       last_owner,
  input  logic       idle,
  output logic [1:0] grant
);

`ifndef CPU7_BIU_ARB_RR_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  // One-hot grant, only ever issued while the arbiter is idle
  always_comb begin
    grant = 2'b00;
    if (idle) begin
`ifdef CPU7_BIU_ARB_RR_EN
      if (ifu_elig && lsu_elig) begin
        if (last_owner == OWN_LSU) begin
          grant[GNT_IFU] = 1'b1;
        end else begin
          grant[GNT_LSU] = 1'b1;
        end
      end else if (lsu_elig) begin
        grant[GNT_LSU] = 1'b1;
      end else if (ifu_elig) begin
        grant[GNT_IFU] = 1'b1;
      end
`else
      if (lsu_elig) begin
        grant[GNT_LSU] = 1'b1;
      end else if (ifu_elig) begin
        grant[GNT_IFU] = 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/cpu7_biu_arb.sv
// cpu7_biu_arb: single-port bus arbiter between instruction fetch and load/store.
// One outstanding bus transaction at a time; a cancelled fetch still completes
// on the bus but its response is swallowed.
// Optional macro CPU7_BIU_ARB_RR_EN selects round-robin arbitration (see pick).
import cpu7_biu_pkg::*;

module cpu7_biu_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            ifu_req,
  input  logic [AW-1:0]   ifu_addr,
  input  logic            ifu_cancel,
  output logic            ifu_ack,
  output logic            ifu_valid,
  output logic [DW-1:0]   ifu_rdata,
  input  logic            lsu_req,
  input  logic            lsu_wr,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wstrb,
  output logic            lsu_ack,
  output logic            lsu_valid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            bus_req,
  output logic            bus_wr,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  output logic [DW/8-1:0] bus_wstrb,
  input  logic            bus_addr_ok,
  input  logic            bus_rvalid,
  input  logic [DW-1:0]   bus_rdata
);

  biu_state_e state;
  biu_state_e state_next;
  logic       owner;
  logic       drop;
  logic       in_idle;
  logic       in_req;
  logic       in_wait;
  logic       ifu_elig;
  logic       lsu_elig;
  logic [1:0] grant;

  assign in_idle  = (state == IDLE);
  assign in_req   = (state == REQ);
  assign in_wait  = (state == WAIT);
  assign ifu_elig = ifu_req & ~ifu_cancel;
  assign lsu_elig = lsu_req;

  cpu7_biu_arb_pick u_pick (
    .ifu_elig   (ifu_elig),
    .lsu_elig   (lsu_elig),
    .last_owner (owner),
    .idle       (in_idle),
    .grant      (grant)
  );

  assign ifu_ack = grant[GNT_IFU];
  assign lsu_ack = grant[GNT_LSU];
  assign bus_req = in_req;

  assign ifu_valid = bus_rvalid & in_wait & (owner == OWN_IFU) & ~drop & ~ifu_cancel;
  assign lsu_valid = bus_rvalid & in_wait & (owner == OWN_LSU);
  assign ifu_rdata = bus_rdata;
  assign lsu_rdata = bus_rdata;

  // State register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: grant starts a request, addr_ok moves to waiting, rvalid ends it
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|grant)     state_next = REQ;
      REQ:     if (bus_addr_ok) state_next = WAIT;
      WAIT:    if (bus_rvalid)  state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Owner doubles as the last-owner history; drop marks a cancelled fetch
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      owner <= OWN_IFU;
      drop  <= 1'b0;
    end else if (grant[GNT_LSU]) begin
      owner <= OWN_LSU;
      drop  <= 1'b0;
    end else if (grant[GNT_IFU]) begin
      owner <= OWN_IFU;
      drop  <= 1'b0;
    end else if ((in_req || in_wait) && (owner == OWN_IFU) && ifu_cancel) begin
      drop  <= 1'b1;
    end
  end

  // Capture the winner's request fields; fetches are plain reads
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end else if (grant[GNT_LSU]) begin
      bus_wr    <= lsu_wr;
      bus_addr  <= lsu_addr;
      bus_wdata <= lsu_wdata;
      bus_wstrb <= lsu_wstrb;
    end else if (grant[GNT_IFU]) begin
      bus_wr    <= 1'b0;
      bus_addr  <= ifu_addr;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end
  end

endmodule

// File: tb/tb_cpu7_biu_arb.sv
// tb_cpu7_biu_arb: self-checking bench for cpu7_biu_arb.
// A transaction-level model tracks the outstanding bus transaction and is
// compared with the DUT on every falling edge; directed scenarios add literal checks.
module tb_cpu7_biu_arb;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_l = 1'b0;
  logic            ifu_req = 1'b0;
  logic [AW-1:0]   ifu_addr = '0;
  logic            ifu_cancel = 1'b0;
  logic            ifu_ack;
  logic            ifu_valid;
  logic [DW-1:0]   ifu_rdata;
  logic            lsu_req = 1'b0;
  logic            lsu_wr = 1'b0;
  logic [AW-1:0]   lsu_addr = '0;
  logic [DW-1:0]   lsu_wdata = '0;
  logic [DW/8-1:0] lsu_wstrb = '0;
  logic            lsu_ack;
  logic            lsu_valid;
  logic [DW-1:0]   lsu_rdata;
  logic            bus_req;
  logic            bus_wr;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic [DW/8-1:0] bus_wstrb;
  logic            bus_addr_ok = 1'b0;
  logic            bus_rvalid = 1'b0;
  logic [DW-1:0]   bus_rdata = '0;

  int checks = 0;
  int failures = 0;

  cpu7_biu_arb #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .ifu_req     (ifu_req),
    .ifu_addr    (ifu_addr),
    .ifu_cancel  (ifu_cancel),
    .ifu_ack     (ifu_ack),
    .ifu_valid   (ifu_valid),
    .ifu_rdata   (ifu_rdata),
    .lsu_req     (lsu_req),
    .lsu_wr      (lsu_wr),
    .lsu_addr    (lsu_addr),
    .lsu_wdata   (lsu_wdata),
    .lsu_wstrb   (lsu_wstrb),
    .lsu_ack     (lsu_ack),
    .lsu_valid   (lsu_valid),
    .lsu_rdata   (lsu_rdata),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wstrb   (bus_wstrb),
    .bus_addr_ok (bus_addr_ok),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction model: one outstanding transaction, its phase, owner and kill flag
  bit            m_busy = 0;
  bit            m_accepted = 0;
  bit            m_lsu = 0;
  bit            m_killed = 0;
  bit            m_last_lsu = 0;
  bit            m_wr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [3:0]    m_wstrb = '0;
  bit            e_ifu_elig, e_lsu_elig, e_g_ifu, e_g_lsu, e_ifu_v, e_lsu_v;

  always @(negedge clk) begin
    if (!rst_l) begin
      m_busy = 0; m_accepted = 0; m_lsu = 0; m_killed = 0; m_last_lsu = 0;
      check_output("m_rst_bus_req", bus_req, 0);
      check_output("m_rst_bus_addr", bus_addr, 0);
      check_output("m_rst_bus_wr", bus_wr, 0);
      check_output("m_rst_bus_wdata", bus_wdata, 0);
      check_output("m_rst_bus_wstrb", bus_wstrb, 0);
      check_output("m_rst_ifu_valid", ifu_valid, 0);
      check_output("m_rst_lsu_valid", lsu_valid, 0);
    end else begin
      e_ifu_elig = ifu_req && !ifu_cancel;
      e_lsu_elig = lsu_req;
      e_g_ifu = 0;
      e_g_lsu = 0;
      if (!m_busy) begin
        if (e_ifu_elig && e_lsu_elig) begin
`ifdef CPU7_BIU_ARB_RR_EN
          if (m_last_lsu) e_g_ifu = 1; else e_g_lsu = 1;
`else
          e_g_lsu = 1;
`endif
        end else begin
          e_g_ifu = e_ifu_elig;
          e_g_lsu = e_lsu_elig;
        end
      end
      check_output("m_ifu_ack", ifu_ack, e_g_ifu);
      check_output("m_lsu_ack", lsu_ack, e_g_lsu);
      check_output("m_bus_req", bus_req, m_busy && !m_accepted);
      if (m_busy && !m_accepted) begin
        check_output("m_bus_addr", bus_addr, m_addr);
        check_output("m_bus_wr", bus_wr, m_wr);
        if (m_lsu) begin
          check_output("m_bus_wdata", bus_wdata, m_wdata);
          check_output("m_bus_wstrb", bus_wstrb, m_wstrb);
        end
      end
      e_ifu_v = m_busy && m_accepted && bus_rvalid && !m_lsu && !m_killed && !ifu_cancel;
      e_lsu_v = m_busy && m_accepted && bus_rvalid && m_lsu;
      check_output("m_ifu_valid", ifu_valid, e_ifu_v);
      check_output("m_lsu_valid", lsu_valid, e_lsu_v);
      if (e_ifu_v) check_output("m_ifu_rdata", ifu_rdata, bus_rdata);
      if (e_lsu_v && !m_wr) check_output("m_lsu_rdata", lsu_rdata, bus_rdata);

      if (m_busy && !m_lsu && ifu_cancel) m_killed = 1;
      if (m_busy && !m_accepted && bus_addr_ok) m_accepted = 1;
      else if (m_busy && m_accepted && bus_rvalid) m_busy = 0;
      if (e_g_ifu || e_g_lsu) begin
        m_busy = 1;
        m_accepted = 0;
        m_killed = 0;
        m_lsu = e_g_lsu;
        m_last_lsu = e_g_lsu;
        m_addr = e_g_lsu ? lsu_addr : ifu_addr;
        m_wr = e_g_lsu && lsu_wr;
        m_wdata = lsu_wdata;
        m_wstrb = lsu_wstrb;
      end
    end
  end

  // Guard against a stuck run
  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  bit won_lsu [3];
  bit exp_won_lsu [3];

  // Directed scenarios with literal expectations
  initial begin
`ifdef CPU7_BIU_ARB_RR_EN
    exp_won_lsu = '{1'b1, 1'b0, 1'b1};
`else
    exp_won_lsu = '{1'b1, 1'b1, 1'b1};
`endif
    repeat (3) step();
    check_output("rst_bus_req", bus_req, 0);
    check_output("rst_bus_addr", bus_addr, 0);
    check_output("rst_ifu_ack", ifu_ack, 0);
    rst_l = 1'b1;
    step();

    // IFU fetch of 0x1c000000
    ifu_req = 1; ifu_addr = 32'h1c000000; #1;
    check_output("t1_ifu_ack", ifu_ack, 1);
    check_output("t1_lsu_ack", lsu_ack, 0);
    step(); ifu_req = 0; #1;
    check_output("t1_bus_req", bus_req, 1);
    check_output("t1_bus_addr", bus_addr, 32'h1c000000);
    check_output("t1_bus_wr", bus_wr, 0);
    step(); bus_addr_ok = 1; #1;
    check_output("t1_bus_req_held", bus_req, 1);
    step(); bus_addr_ok = 0; #1;
    check_output("t1_bus_req_drop", bus_req, 0);
    step(); bus_rvalid = 1; bus_rdata = 32'h02800000; #1;
    check_output("t1_ifu_valid", ifu_valid, 1);
    check_output("t1_ifu_rdata", ifu_rdata, 32'h02800000);
    step(); bus_rvalid = 0;

    // LSU write to 0x100, strobes 0011
    lsu_req = 1; lsu_wr = 1; lsu_addr = 32'h100; lsu_wdata = 32'hdeadbeef; lsu_wstrb = 4'b0011; #1;
    check_output("t2_lsu_ack", lsu_ack, 1);
    step(); lsu_req = 0; lsu_wr = 0; lsu_wstrb = 4'b0000; lsu_wdata = 0; #1;
    check_output("t2_bus_wr", bus_wr, 1);
    check_output("t2_bus_wstrb", bus_wstrb, 4'b0011);
    check_output("t2_bus_wdata", bus_wdata, 32'hdeadbeef);
    step(); #1;
    check_output("t2_bus_wr_held", bus_wr, 1);
    check_output("t2_bus_wstrb_held", bus_wstrb, 4'b0011);
    step(); bus_addr_ok = 1;
    step(); bus_addr_ok = 0;
    step(); bus_rvalid = 1; bus_rdata = 32'h0; #1;
    check_output("t2_lsu_valid", lsu_valid, 1);
    check_output("t2_ifu_valid", ifu_valid, 0);
    step(); bus_rvalid = 0;

    // Reset to restore the last-owner history, then three tie rounds
    rst_l = 0; step(); step(); rst_l = 1; step();
    ifu_req = 1; lsu_req = 1; ifu_addr = 32'h1c000080; lsu_addr = 32'h200; lsu_wr = 0;
    for (int r = 0; r < 3; r++) begin
      #1;
      won_lsu[r] = lsu_ack;
      check_output("t3_single_ack", ifu_ack ^ lsu_ack, 1);
      step(); bus_addr_ok = 1;
      if (won_lsu[r]) lsu_req = 0; else ifu_req = 0;
      step(); bus_addr_ok = 0; bus_rvalid = 1; bus_rdata = 32'h1000 + r;
      step(); bus_rvalid = 0;
      if (r < 2) begin
        if (won_lsu[r]) lsu_req = 1; else ifu_req = 1;
      end else begin
        ifu_req = 0; lsu_req = 0;
      end
    end
    for (int r = 0; r < 3; r++) check_output("t3_round_winner_lsu", won_lsu[r], exp_won_lsu[r]);
    step();

    // Cancel in WAIT, then a fresh fetch to 0x1c000040
    ifu_req = 1; ifu_addr = 32'h1c000020; #1;
    check_output("t4_ifu_ack", ifu_ack, 1);
    step(); ifu_req = 0; bus_addr_ok = 1;
    step(); bus_addr_ok = 0; ifu_cancel = 1;
    step(); ifu_cancel = 0; bus_rvalid = 1; bus_rdata = 32'hbad0bad0; #1;
    check_output("t4_dropped_ifu_valid", ifu_valid, 0);
    check_output("t4_dropped_lsu_valid", lsu_valid, 0);
    step(); bus_rvalid = 0; ifu_req = 1; ifu_addr = 32'h1c000040; #1;
    check_output("t4_regrant_ack", ifu_ack, 1);
    step(); ifu_req = 0; bus_addr_ok = 1; #1;
    check_output("t4_regrant_addr", bus_addr, 32'h1c000040);
    step(); bus_addr_ok = 0;
    step(); bus_rvalid = 1; bus_rdata = 32'h03400000; #1;
    check_output("t4_new_ifu_valid", ifu_valid, 1);
    check_output("t4_new_ifu_rdata", ifu_rdata, 32'h03400000);
    step(); bus_rvalid = 0;

    // Cancel alongside a request in IDLE, then cancel coinciding with rvalid
    ifu_req = 1; ifu_cancel = 1; ifu_addr = 32'h1c000100; #1;
    check_output("t5_cancel_blocks_ack", ifu_ack, 0);
    step(); ifu_cancel = 0; #1;
    check_output("t5_late_ack", ifu_ack, 1);
    step(); ifu_req = 0; bus_addr_ok = 1;
    step(); bus_addr_ok = 0;
    step();
    step(); bus_rvalid = 1; bus_rdata = 32'h11112222; ifu_cancel = 1; #1;
    check_output("t5_cancel_rvalid_same", ifu_valid, 0);
    step(); bus_rvalid = 0; ifu_cancel = 0;

    // Cancel has no effect on an LSU read
    lsu_req = 1; lsu_wr = 0; lsu_addr = 32'h300; #1;
    check_output("t5_lsu_ack", lsu_ack, 1);
    step(); lsu_req = 0; bus_addr_ok = 1; ifu_cancel = 1;
    step(); bus_addr_ok = 0; ifu_cancel = 0;
    step(); bus_rvalid = 1; bus_rdata = 32'h000055aa; ifu_cancel = 1; #1;
    check_output("t5_lsu_valid_cancel", lsu_valid, 1);
    check_output("t5_lsu_rdata", lsu_rdata, 32'h000055aa);
    step(); bus_rvalid = 0; ifu_cancel = 0;

    // Reset in WAIT abandons the transaction
    ifu_req = 1; ifu_addr = 32'h1c000200;
    step(); ifu_req = 0; bus_addr_ok = 1;
    step(); bus_addr_ok = 0; rst_l = 0; #1;
    check_output("t6_rst_bus_req", bus_req, 0);
    check_output("t6_rst_bus_addr", bus_addr, 0);
    step(); rst_l = 1;
    step(); bus_rvalid = 1; bus_rdata = 32'h77777777; #1;
    check_output("t6_stale_ifu_valid", ifu_valid, 0);
    check_output("t6_stale_lsu_valid", lsu_valid, 0);
    step(); bus_rvalid = 0; bus_addr_ok = 1;
    step(); bus_addr_ok = 0; #1;
    check_output("t6_idle_addr_ok_ignored", bus_req, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
